sin_cos_nco: RTL and testbench

Parametrised numerically controlled sine/cosine generator, the successor to the free-running `sin_cos` block. It adds a programmable phase accumulator, a one-shot phase-to-sin/cos mode and valid/ready handshakes. Results come from an iterative CORDIC engine. The block feeds modulators and test-signal paths that previously used fixed-rate `sin_cos`.

---
 rtl/sin_cos_pkg.sv | 32 +++
 rtl/cordic_iter_core.sv | 96 +++++++++
 rtl/sin_cos_nco.sv | 110 +++++++++++
 tb/tb_sin_cos_nco.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sin_cos_pkg.sv
// Shared types and elaboration-time constants for the sin_cos_nco generator:
// FSM states, CORDIC arctangent table / gain-compensated start vector, dither LFSR.
package sin_cos_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    HOLD
  } state_t;

  localparam real PI_R = 3.14159265358979323846;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // atan(2^-i) in angle units where 2^(zw-1) represents pi.
  function automatic longint atan_tab(input int i, input int zw);
    return longint'($atan(1.0 / (2.0 ** i)) / PI_R * (2.0 ** (zw - 1)));
  endfunction

  // Start x so the CORDIC gain brings the final vector to full scale.
  function automatic longint cordic_x0(input int width, input int iters);
    real k;
    k = 1.0;
    for (int i = 0; i < iters; i++) begin
      k = k / $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    return longint'(k * ((2.0 ** (width - 1)) - 1.0));
  endfunction

endpackage

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC rotation engine: quadrant fold on start, one micro-rotation
// per cycle while run is high, then quadrant sign/swap and saturation into sin/cos.
module cordic_iter_core
  import sin_cos_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int ITERS = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    run,
  input  logic [WIDTH+1:0]        phase,
  output logic                    last,
  output logic signed [WIDTH-1:0] sin,
  output logic signed [WIDTH-1:0] cos
);

  localparam int ZW = WIDTH + 2;
  localparam int CW = $clog2(ITERS + 1);
  localparam logic signed [ZW-1:0] X0 = ZW'(cordic_x0(WIDTH, ITERS));
  localparam logic signed [ZW-1:0] FS = ZW'((longint'(1) << (WIDTH - 1)) - 1);

  logic signed [ZW-1:0] atan_rom [2**CW];

  for (genvar g = 0; g < 2**CW; g++) begin : g_atan
    localparam logic signed [ZW-1:0] A = (g < ITERS) ? ZW'(atan_tab(g, ZW)) : '0;
    assign atan_rom[g] = A;
  end

  logic signed [ZW-1:0] x, y, z;
  logic signed [ZW-1:0] x_sh, y_sh;
  logic signed [ZW-1:0] s_sel, c_sel;
  logic [1:0]           quad;
  logic [CW-1:0]        cnt;

  assign x_sh = x >>> cnt;
  assign y_sh = y >>> cnt;
  assign last = (cnt == CW'(ITERS));

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ZW-1:0] v);
    if (v > FS) return WIDTH'(FS);
    else if (v < -FS) return WIDTH'(-FS);
    else return v[WIDTH-1:0];
  endfunction

  // NOTE: every variable gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    s_sel = y;
    c_sel = x;
    case (quad)
      2'd1: begin s_sel = x;  c_sel = -y; end
      2'd2: begin s_sel = -y; c_sel = -x; end
      2'd3: begin s_sel = -x; c_sel = y;  end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours (x and y swap cleanly).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      quad <= '0;
      cnt  <= '0;
      sin  <= '0;
      cos  <= '0;
    end else if (start) begin
      x    <= X0;
      y    <= '0;
      z    <= {2'b00, phase[WIDTH-1:0]};
      quad <= phase[ZW-1 -: 2];
      cnt  <= '0;
    end else if (run) begin
      if (!last) begin
        if (!z[ZW-1]) begin
          x <= x - y_sh;
          y <= y + x_sh;
          z <= z - atan_rom[cnt];
        end else begin
          x <= x + y_sh;
          y <= y - x_sh;
          z <= z + atan_rom[cnt];
        end
        cnt <= cnt + CW'(1);
      end else begin
        sin <= sat(s_sel);
        cos <= sat(c_sel);
      end
    end
  end

endmodule

// File: rtl/sin_cos_nco.sv
// Sine/cosine NCO: phase accumulator, one-shot mode and valid/ready handshakes
// around cordic_iter_core. Optional phase dither enabled by SIN_COS_DITHER_EN.
module sin_cos_nco
  import sin_cos_pkg::*;
#(
  parameter int WIDTH   = 21,
  parameter int PHASE_W = 32,
  parameter int ITERS   = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    freq_we,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PHASE_W-1:0]      phase_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] sin,
  output logic signed [WIDTH-1:0] cos,
  output logic [PHASE_W-1:0]      phase_out
);

  state_t state, next_state;

  logic                  hs;
  logic                  core_last;
  logic [PHASE_W-1:0]    acc, freq, p_sel, p_lat;
  logic [WIDTH+1:0]      fold_phase;

  assign hs    = in_valid & in_ready;
  assign p_sel = mode ? phase_in : acc;

`ifdef SIN_COS_DITHER_EN
  localparam int DLSB = PHASE_W - WIDTH - 18;

  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] dith, p_dith;

  // Dither lands just below the CORDIC angle resolution; narrow phases keep its top bits.
  if (DLSB >= 0) begin : g_dith_full
    assign dith = PHASE_W'(lfsr) << DLSB;
  end else begin : g_dith_clip
    assign dith = PHASE_W'(lfsr >> (-DLSB));
  end

  assign p_dith     = p_sel + dith;
  assign fold_phase = p_dith[PHASE_W-1 -: WIDTH+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else if (hs) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  end
`else
  assign fold_phase = p_sel[PHASE_W-1 -: WIDTH+2];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hs)        next_state = ROTATE;
      ROTATE:  if (core_last) next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state, so they are low
  // while reset is held and independent of in_valid combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      freq      <= '0;
      p_lat     <= '0;
      phase_out <= '0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == HOLD);
      if (hs) begin
        p_lat <= p_sel;
        if (!mode) acc <= acc + freq;
      end
      if (freq_we) freq <= freq_word;
      if (state == ROTATE && core_last) phase_out <= p_lat;
    end
  end

  cordic_iter_core #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .start (hs),
    .run   (state == ROTATE),
    .phase (fold_phase),
    .last  (core_last),
    .sin   (sin),
    .cos   (cos)
  );

endmodule

// File: tb/tb_sin_cos_nco.sv
// Self-checking bench for sin_cos_nco: a real-arithmetic model predicts every
// result; directed vectors pin latency, quadrants, backpressure, reset and NCO stepping.
module tb_sin_cos_nco;

  localparam int     WIDTH   = 21;
  localparam int     PHASE_W = 32;
  localparam int     ITERS   = 18;
  localparam longint FS      = 1048575;
  localparam longint TOL     = 24;
  localparam real    PI_R    = 3.14159265358979323846;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    freq_we = 1'b0;
  logic [PHASE_W-1:0]      freq_word = '0;
  logic                    mode = 1'b0;
  logic                    in_valid = 1'b0;
  logic [PHASE_W-1:0]      phase_in = '0;
  logic                    out_ready = 1'b0;
  logic                    in_ready, out_valid;
  logic signed [WIDTH-1:0] sin, cos;
  logic [PHASE_W-1:0]      phase_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int xfers = 0;

  logic [PHASE_W-1:0] exp_q [$];
  logic [PHASE_W-1:0] seen_q [$];
  int                 hs_cyc [$];
  logic [PHASE_W-1:0] m_acc = '0;
  logic [PHASE_W-1:0] m_freq = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sin_cos_nco #(
    .WIDTH   (WIDTH),
    .PHASE_W (PHASE_W),
    .ITERS   (ITERS)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .freq_we   (freq_we),
    .freq_word (freq_word),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .phase_in  (phase_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sin       (sin),
    .cos       (cos),
    .phase_out (phase_out)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp,
                           input longint tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic real angle(input logic [PHASE_W-1:0] p);
    return 2.0 * PI_R * real'(longint'(p)) / 4294967296.0;
  endfunction

  function automatic longint model_sin(input logic [PHASE_W-1:0] p);
    return longint'(real'(FS) * $sin(angle(p)));
  endfunction

  function automatic longint model_cos(input logic [PHASE_W-1:0] p);
    return longint'(real'(FS) * $cos(angle(p)));
  endfunction

  // Model and compare process: looks at the DUT half a cycle before each edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc  = '0;
      m_freq = '0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out_valid: got 1 expected 0");
        end else begin
          check("phase_out", longint'(phase_out), longint'(exp_q[0]));
          check_tol("sin", longint'(sin), model_sin(exp_q[0]), TOL);
          check_tol("cos", longint'(cos), model_cos(exp_q[0]), TOL);
          if (out_ready) begin
            seen_q.push_back(phase_out);
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
      if (in_valid && in_ready) begin
        hs_cyc.push_back(cyc);
        if (mode) exp_q.push_back(phase_in);
        else begin
          exp_q.push_back(m_acc);
          m_acc = m_acc + m_freq;
        end
      end
      if (freq_we) m_freq = freq_word;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic m, input logic [PHASE_W-1:0] ph);
    logic r;
    logic ok;
    ok = 1'b0;
    mode = m;
    phase_in = ph;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("request_accepted", 0, 1);
  endtask

  // Returns on the negedge where out_valid is first seen; lat counts edges to the consumer.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) return;
    end
    check("out_valid_timeout", longint'(out_valid), 1);
  endtask

  task automatic oneshot(input logic [PHASE_W-1:0] ph, input longint es, input longint ec,
                         input string name);
    int lat;
    request(1'b1, ph);
    wait_valid(lat);
    check({name, "_latency"}, lat, ITERS + 2);
    check_tol({name, "_sin"}, longint'(sin), es, TOL);
    check_tol({name, "_cos"}, longint'(cos), ec, TOL);
    check({name, "_sin_in_range"}, longint'(sin <= FS && sin >= -FS), 1);
    check({name, "_cos_in_range"}, longint'(cos <= FS && cos >= -FS), 1);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n0, h0, x0;
    logic signed [WIDTH-1:0] s0, c0;

    // Reset state
    #3 rst_n = 1'b0;
    step(3);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_sin", longint'(sin), 0);
    check("rst_cos", longint'(cos), 0);
    check("rst_phase_out", longint'(phase_out), 0);
    rst_n = 1'b1;
    step(1);
    check("rel_in_ready", longint'(in_ready), 1);

    // One-shot quadrants and a few interior angles
    out_ready = 1'b1;
    oneshot(32'h0000_0000, 0, FS, "ph0");
    oneshot(32'h4000_0000, FS, 0, "ph90");
    oneshot(32'h8000_0000, 0, -FS, "ph180");
    oneshot(32'hC000_0000, -FS, 0, "ph270");
    oneshot(32'h2000_0000, 741455, 741455, "ph45");
    oneshot(32'h1555_5555, 524288, 908093, "ph30");

    // Backpressure
    out_ready = 1'b0;
    request(1'b1, 32'h6000_0000);
    wait_valid(lat);
    check_tol("bp_sin", longint'(sin), 741455, TOL);
    check_tol("bp_cos", longint'(cos), -741455, TOL);
    s0 = sin;
    c0 = cos;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_sin_stable", longint'(sin), longint'(s0));
      check("bp_cos_stable", longint'(cos), longint'(c0));
    end
    x0 = xfers;
    step(1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(2);
    check("bp_one_transfer", xfers, x0 + 1);
    check("bp_out_valid_after", longint'(out_valid), 0);
    check("bp_in_ready_after", longint'(in_ready), 1);

    // Reset in the middle of a rotation
    request(1'b1, 32'h2000_0000);
    step(5);
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    check("mid_rst_sin", longint'(sin), 0);
    check("mid_rst_cos", longint'(cos), 0);
    check("mid_rst_phase_out", longint'(phase_out), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("mid_rel_in_ready", longint'(in_ready), 1);
    step(30);
    check("mid_rel_no_result", longint'(out_valid), 0);

    // NCO free-run, 2^28 per sample
    out_ready = 1'b1;
    freq_word = 32'h1000_0000;
    freq_we = 1'b1;
    step(1);
    freq_we = 1'b0;
    mode = 1'b0;
    n0 = seen_q.size();
    h0 = hs_cyc.size();
    in_valid = 1'b1;
    for (int k = 0; k < 600 && seen_q.size() < n0 + 17; k++) step(1);
    in_valid = 1'b0;
    step(30);
    check("nco_samples", longint'(seen_q.size() >= n0 + 17), 1);
    if (seen_q.size() >= n0 + 17) begin
      for (int k = 0; k < 17; k++) begin
        logic [PHASE_W-1:0] e;
        e = PHASE_W'(longint'(k % 16) << 28);
        check($sformatf("nco_phase_%0d", k), longint'(seen_q[n0 + k]), longint'(e));
      end
      for (int k = 1; k < 17; k++) begin
        check($sformatf("nco_spacing_%0d", k), hs_cyc[h0 + k] - hs_cyc[h0 + k - 1],
              ITERS + 3);
      end
    end

    // Frequency write coinciding with an NCO handshake
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    freq_word = 32'd100;
    freq_we = 1'b1;
    step(1);
    freq_word = 32'd7;
    mode = 1'b0;
    in_valid = 1'b1;
    step(1);
    freq_we = 1'b0;
    n0 = seen_q.size();
    for (int k = 0; k < 300 && seen_q.size() < n0 + 3; k++) step(1);
    in_valid = 1'b0;
    step(30);
    check("fw_samples", longint'(seen_q.size() >= n0 + 3), 1);
    if (seen_q.size() >= n0 + 3) begin
      check("fw_phase_0", longint'(seen_q[n0]), 0);
      check("fw_phase_1", longint'(seen_q[n0 + 1]), 100);
      check("fw_phase_2", longint'(seen_q[n0 + 2]), 107);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
